backprop_error_stage: RTL and testbench
=======================================

BACKPROP_ERROR_STAGE -- requirements
Module: backprop_error_stage

Interface
REQ-001 Parameter BATCH_LOG2, default 2: log2 of the number of samples averaged per emitted error (range 0..8).
REQ-002 Parameter SHIFT, default 0: extra arithmetic right shift applied to the averaged error, acting as the learning-rate scale (range 0..16).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port out_valid, input, 1 bit: the neuron output sample is valid.
REQ-006 Port out_value, input, 32 bits: neuron output, signed two's complement.
REQ-007 Port target, input, 32 bits: expected output, signed; sampled together with out_value.
REQ-008 Port out_ready, output, 1 bit: block can accept a sample.
REQ-009 Port clear, input, 1 bit: synchronous abort of the current batch.
REQ-010 Port err_valid, output, 1 bit: err holds a valid backprop start value.
REQ-011 Port err, output, 32 bits: signed error fed to the learning neuron's backprop start input.
REQ-012 Port err_ready, input, 1 bit: downstream neuron accepts err.
REQ-013 Port epoch_count, output, 16 bits: count of errors delivered.

Function
REQ-014 Two states: ACC (out_ready=1, err_valid=0) and SEND (out_ready=0, err_valid=1).
REQ-015 Accept = out_valid && out_ready; on accept, the block SHALL add diff = target - out_value, computed at 33-bit signed width, to acc, a signed accumulator of width 33+BATCH_LOG2, and increment cnt.
REQ-016 On the accept that makes cnt reach 2^BATCH_LOG2:
- register err = acc_next >>> (BATCH_LOG2+SHIFT), reduced to 32 bits per REQ-025/026;
- go to SEND, so err_valid rises the cycle after that accept (latency 1).
REQ-017 In SEND, err and err_valid SHALL stay stable until err_valid && err_ready.
REQ-018 On handshake: go to ACC, clear acc and cnt, epoch_count += 1 (wraps 0xFFFF -> 0).
REQ-019 out_ready SHALL be 0 throughout SEND, including the handshake cycle; the next sample is accepted one cycle after the handshake at the earliest.
REQ-020 clear=1 in any state:
- next state ACC, acc=0, cnt=0, err_valid=0;
- err holds its last value; epoch_count unchanged;
- clear wins over a simultaneous accept or handshake, and that sample or error is dropped.
REQ-021 out_valid while out_ready=0 SHALL have no effect; inputs are not buffered.
REQ-022 BATCH_LOG2=0: every accept goes straight to SEND with err = diff >>> SHIFT.

Reset
REQ-023 While rst_n=0, the block SHALL asynchronously force: state=ACC, acc=0, cnt=0, err=0, err_valid=0, out_ready=1 after deassertion, epoch_count=0.
REQ-024 Reset mid-batch or mid-SEND SHALL discard all partial state; the first accept after release starts a fresh batch.

Configuration
REQ-025 With macro BPE_SATURATE_EN defined, a shifted result above 0x7FFFFFFF SHALL clamp to 0x7FFFFFFF, and one below 0x80000000 SHALL clamp to 0x80000000.
REQ-026 Without BPE_SATURATE_EN, the result SHALL be truncated to its low 32 bits (wrap); all other behaviour is identical.

Verification
REQ-027 Average: BATCH_LOG2=2, SHIFT=0, target=10, out_value=2,4,6,8 on consecutive cycles -> err=5 with err_valid=1 exactly one cycle after the 4th accept; epoch_count=1 after handshake.
REQ-028 Backpressure: err_ready=0 for 3 cycles in SEND -> err stays 5, err_valid=1 and out_ready=0 for all 3 cycles; samples presented then are ignored.
REQ-029 Saturation: BATCH_LOG2=0, target=0x7FFFFFFF, out_value=0x80000000 -> err=0x7FFFFFFF with BPE_SATURATE_EN, err=0xFFFFFFFF without it.
REQ-030 Shift and sign: BATCH_LOG2=0, SHIFT=2, target=0, out_value=9 -> err=0xFFFFFFFD (-3, arithmetic shift of -9).
REQ-031 Clear collision: clear=1 on the same cycle as the 4th accept -> err_valid stays 0, cnt=0, and the next 4 samples form a complete new batch.
REQ-032 Reset: rst_n pulsed low mid-SEND, asynchronously to clk -> err_valid=0, err=0 and epoch_count=0 immediately; out_ready=1 on the first edge after release.

Source files
------------

// File: rtl/backprop_error_stage_if.sv
// rtl/backprop_error_stage_if.sv - sample-in / error-out handshake bundle for backprop_error_stage
interface backprop_error_stage_if;
    logic        out_valid;
    logic [31:0] out_value;
    logic [31:0] target;
    logic        out_ready;
    logic        err_valid;
    logic [31:0] err;
    logic        err_ready;

    modport master (
        output out_valid, out_value, target, err_ready,
        input  out_ready, err_valid, err
    );

    modport slave (
        input  out_valid, out_value, target, err_ready,
        output out_ready, err_valid, err
    );
endinterface

// File: rtl/backprop_error_stage.sv
// rtl/backprop_error_stage.sv - batch-averaged (target - output) error for backprop start
// Optional feature macro: BPE_SATURATE_EN (clamp scaled error to 32-bit signed range).
module backprop_error_stage #(
    parameter int BATCH_LOG2 = 2,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    backprop_error_stage_if.slave bus,
    output logic [15:0]           epoch_count
);

    localparam int AW          = 33 + BATCH_LOG2;
    localparam int CW          = BATCH_LOG2 + 1;
    localparam int TOTAL_SHIFT = BATCH_LOG2 + SHIFT;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << BATCH_LOG2) - 1);

    typedef enum logic {ACC, SEND} state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           err_q, err_d;
    logic [15:0]           epoch_q, epoch_d;

    logic signed [32:0]    diff;
    logic signed [AW-1:0]  diff_ext;
    logic signed [AW-1:0]  acc_next;
    logic [31:0]           err_next;

    // 33 bits holds any difference of two 32-bit signed values without overflow
    assign diff     = $signed({bus.target[31], bus.target}) - $signed({bus.out_value[31], bus.out_value});
    assign diff_ext = AW'(diff);
    assign acc_next = acc_q + diff_ext;

`ifdef BPE_SATURATE_EN
    logic signed [AW-1:0] shifted;
    logic                 sat_hi;
    logic                 sat_lo;

    assign shifted = acc_next >>> TOTAL_SHIFT;
    // Bits above bit 31 must all match the sign bit for the value to fit in 32 bits
    assign sat_hi  = !shifted[AW-1] &&  (|shifted[AW-2:31]);
    assign sat_lo  =  shifted[AW-1] && !(&shifted[AW-2:31]);

    always_comb begin
        err_next = shifted[31:0];
        if (sat_hi) begin
            err_next = 32'h7FFF_FFFF;
        end else if (sat_lo) begin
            err_next = 32'h8000_0000;
        end
    end
`else
    assign err_next = 32'(acc_next >>> TOTAL_SHIFT);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        epoch_d = epoch_q;
        if (clear) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (bus.out_valid) begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            err_d   = err_next;
                            state_d = SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.err_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        epoch_d = epoch_q + 16'd1;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            epoch_q <= epoch_d;
        end
    end

    assign bus.out_ready = (state_q == ACC);
    assign bus.err_valid = (state_q == SEND);
    assign bus.err       = err_q;
    assign epoch_count   = epoch_q;

endmodule

// File: tb/tb_backprop_error_stage.sv
// tb/tb_backprop_error_stage.sv - directed self-checking bench for backprop_error_stage
module tb_backprop_error_stage;

`ifdef BPE_SATURATE_EN
    localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SAT_EXP = 32'hFFFF_FFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c0 = 1'b0, c1 = 1'b0, c2 = 1'b0;
    logic [15:0] e0, e1, e2;
    int          passed = 0;
    int          total = 0;

    backprop_error_stage_if i0 ();
    backprop_error_stage_if i1 ();
    backprop_error_stage_if i2 ();

    backprop_error_stage #(.BATCH_LOG2(2), .SHIFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(c0), .bus(i0.slave), .epoch_count(e0));
    backprop_error_stage #(.BATCH_LOG2(0), .SHIFT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(c1), .bus(i1.slave), .epoch_count(e1));
    backprop_error_stage #(.BATCH_LOG2(0), .SHIFT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(c2), .bus(i2.slave), .epoch_count(e2));

    always #5 clk = ~clk;

    task automatic drive0(input logic [31:0] t, input logic [31:0] v);
        i0.out_valid = 1'b1;
        i0.target    = t;
        i0.out_value = v;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #12;
        total++; if (i0.err_valid !== 1'b0) $display("FAIL reset_err_valid got %b exp 0", i0.err_valid); else passed++;
        total++; if (i0.err !== 32'd0) $display("FAIL reset_err got %h exp 0", i0.err); else passed++;
        total++; if (i0.out_ready !== 1'b1) $display("FAIL reset_out_ready got %b exp 1", i0.out_ready); else passed++;
        total++; if (e0 !== 16'd0) $display("FAIL reset_epoch got %0d exp 0", e0); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_average;
        logic [31:0] outs [4];
        outs[0] = 32'd2; outs[1] = 32'd4; outs[2] = 32'd6; outs[3] = 32'd8;
        i0.err_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                total++; if (i0.err_valid !== 1'b0) $display("FAIL avg_early_valid got %b exp 0", i0.err_valid); else passed++;
            end
            drive0(32'd10, outs[k]);
        end
        i0.out_valid = 1'b0;
        total++; if (i0.err_valid !== 1'b1) $display("FAIL avg_valid got %b exp 1", i0.err_valid); else passed++;
        total++; if (i0.err !== 32'd5) $display("FAIL avg_err got %h exp 5", i0.err); else passed++;
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 3; k++) begin
            i0.out_valid = 1'b1;
            i0.target    = 32'd1000;
            i0.out_value = 32'd0;
            @(negedge clk);
            total++; if (i0.err !== 32'd5) $display("FAIL bp_err got %h exp 5", i0.err); else passed++;
            total++; if (i0.err_valid !== 1'b1) $display("FAIL bp_valid got %b exp 1", i0.err_valid); else passed++;
            total++; if (i0.out_ready !== 1'b0) $display("FAIL bp_out_ready got %b exp 0", i0.out_ready); else passed++;
        end
        i0.out_valid = 1'b0;
        i0.err_ready = 1'b1;
        @(negedge clk);
        total++; if (i0.err_valid !== 1'b0) $display("FAIL hs_valid got %b exp 0", i0.err_valid); else passed++;
        total++; if (i0.out_ready !== 1'b1) $display("FAIL hs_out_ready got %b exp 1", i0.out_ready); else passed++;
        total++; if (e0 !== 16'd1) $display("FAIL hs_epoch got %0d exp 1", e0); else passed++;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++) drive0(32'd0, 32'd4);
        i0.out_valid = 1'b0;
        total++; if (i0.err_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", i0.err_valid); else passed++;
        total++; if (i0.err !== 32'hFFFF_FFFC) $display("FAIL b2b_err got %h exp fffffffc", i0.err); else passed++;
        @(negedge clk);
        total++; if (e0 !== 16'd2) $display("FAIL b2b_epoch got %0d exp 2", e0); else passed++;
    endtask

    task automatic test_clear_collision;
        for (int k = 0; k < 3; k++) drive0(32'd100, 32'd0);
        c0 = 1'b1;
        drive0(32'd100, 32'd0);
        c0 = 1'b0;
        i0.out_valid = 1'b0;
        total++; if (i0.err_valid !== 1'b0) $display("FAIL clr_valid got %b exp 0", i0.err_valid); else passed++;
        total++; if (i0.err !== 32'hFFFF_FFFC) $display("FAIL clr_err_hold got %h exp fffffffc", i0.err); else passed++;
        total++; if (e0 !== 16'd2) $display("FAIL clr_epoch got %0d exp 2", e0); else passed++;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                total++; if (i0.err_valid !== 1'b0) $display("FAIL clr_new_early got %b exp 0", i0.err_valid); else passed++;
            end
            drive0(32'd8, 32'd0);
        end
        i0.out_valid = 1'b0;
        total++; if (i0.err_valid !== 1'b1) $display("FAIL clr_new_valid got %b exp 1", i0.err_valid); else passed++;
        total++; if (i0.err !== 32'd8) $display("FAIL clr_new_err got %h exp 8", i0.err); else passed++;
        @(negedge clk);
        total++; if (e0 !== 16'd3) $display("FAIL clr_new_epoch got %0d exp 3", e0); else passed++;
    endtask

    task automatic test_saturation;
        i1.err_ready = 1'b0;
        i1.out_valid = 1'b1;
        i1.target    = 32'h7FFF_FFFF;
        i1.out_value = 32'h8000_0000;
        @(negedge clk);
        i1.out_valid = 1'b0;
        total++; if (i1.err_valid !== 1'b1) $display("FAIL sat_valid got %b exp 1", i1.err_valid); else passed++;
        total++; if (i1.err !== SAT_EXP) $display("FAIL sat_err got %h exp %h", i1.err, SAT_EXP); else passed++;
        i1.err_ready = 1'b1;
        @(negedge clk);
        total++; if (e1 !== 16'd1) $display("FAIL sat_epoch got %0d exp 1", e1); else passed++;
    endtask

    task automatic test_shift_sign;
        i2.err_ready = 1'b1;
        i2.out_valid = 1'b1;
        i2.target    = 32'd0;
        i2.out_value = 32'd9;
        @(negedge clk);
        i2.out_valid = 1'b0;
        total++; if (i2.err_valid !== 1'b1) $display("FAIL shift_valid got %b exp 1", i2.err_valid); else passed++;
        total++; if (i2.err !== 32'hFFFF_FFFD) $display("FAIL shift_err got %h exp fffffffd", i2.err); else passed++;
    endtask

    task automatic test_reset_async;
        i0.err_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive0(32'd20, 32'd0);
        i0.out_valid = 1'b0;
        total++; if (i0.err !== 32'd20) $display("FAIL ar_pre_err got %h exp 14", i0.err); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (i0.err_valid !== 1'b0) $display("FAIL ar_valid got %b exp 0", i0.err_valid); else passed++;
        total++; if (i0.err !== 32'd0) $display("FAIL ar_err got %h exp 0", i0.err); else passed++;
        total++; if (e0 !== 16'd0) $display("FAIL ar_epoch got %0d exp 0", e0); else passed++;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (i0.out_ready !== 1'b1) $display("FAIL ar_out_ready got %b exp 1", i0.out_ready); else passed++;
        @(negedge clk);
        for (int k = 0; k < 4; k++) drive0(32'd4, 32'd0);
        i0.out_valid = 1'b0;
        total++; if (i0.err_valid !== 1'b1) $display("FAIL ar_fresh_valid got %b exp 1", i0.err_valid); else passed++;
        total++; if (i0.err !== 32'd4) $display("FAIL ar_fresh_err got %h exp 4", i0.err); else passed++;
    endtask

    initial begin
        i0.out_valid = 1'b0; i0.out_value = '0; i0.target = '0; i0.err_ready = 1'b0;
        i1.out_valid = 1'b0; i1.out_value = '0; i1.target = '0; i1.err_ready = 1'b0;
        i2.out_valid = 1'b0; i2.out_value = '0; i2.target = '0; i2.err_ready = 1'b0;
        test_reset;
        test_average;
        test_backpressure;
        test_back_to_back;
        test_clear_collision;
        test_saturation;
        test_shift_sign;
        test_reset_async;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
